// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline types: the IF/ID buffer packet and the fetch FSM encoding.
package if_fetch_stage_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    curr_pc;
        logic [INSTR_W-1:0] curr_instr;
    } if_id_reg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of if_id_reg packets. The head is presented directly
// from storage; an empty FIFO presents an all-zero packet.
module fetch_fifo
    import if_fetch_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  if_id_reg         wr_data,
    output if_id_reg         rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count
);

    if_id_reg         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers and occupancy; flush empties the FIFO, a same-cycle pop is subsumed.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding fetch FSM, redirect handling,
// and the IF/ID buffer FIFO feeding decode.
//
// state  | meaning
// F_IDLE | no request outstanding; stray responses are ignored
// F_WAIT | one live request outstanding; its response gets buffered
// F_DROP | one stale request outstanding (redirected); its response is discarded
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int              BUF_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC  = 9'h000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    input  logic                       id_ready,
    output logic                       ifid_valid,
    output logic [PC_W+INSTR_W-1:0]    ifid_pkt
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  req_pc_q;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occ_next;
    logic             push, pop, fire, space;
    if_id_reg         fifo_head;
    if_id_reg         fifo_wr;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A response in WAIT consumes the slot its request reserved, so occupancy
    // after this cycle must leave room before a new request may go out.
    assign push     = (state_q == F_WAIT) && imem_rvalid && !redirect;
    assign pop      = ifid_valid && id_ready;
    assign occ_next = OCC_W'(fifo_count) + OCC_W'(push) - OCC_W'(pop);
    assign space    = occ_next < OCC_W'(BUF_DEPTH);

    assign imem_req  = !reset && !redirect && space &&
                       ((state_q == F_IDLE) || ((state_q == F_WAIT) && imem_rvalid));
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= F_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: a redirect with no response yet leaves a stale request to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE: if (fire) state_d = F_WAIT;
            F_WAIT: begin
                if (redirect)         state_d = imem_rvalid ? F_IDLE : F_DROP;
                else if (imem_rvalid) state_d = fire ? F_WAIT : F_IDLE;
            end
            F_DROP: if (imem_rvalid) state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    // PC update: redirect wins over the sequential increment; wraps modulo 512.
    always_ff @(posedge clk) begin
        if (reset)         pc_q <= {RESET_PC[PC_W-1:2], 2'b00};
        else if (redirect) pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
        else if (fire)     pc_q <= pc_q + PC_W'(4);
    end

    // Remember the address of the outstanding request to tag its response.
    always_ff @(posedge clk) begin
        if (reset)     req_pc_q <= {RESET_PC[PC_W-1:2], 2'b00};
        else if (fire) req_pc_q <= pc_q;
    end

    assign fifo_wr.curr_pc    = req_pc_q;
    assign fifo_wr.curr_instr = imem_rdata;

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .wr_data  (fifo_wr),
        .rd_data  (fifo_head),
        .rd_valid (ifid_valid),
        .count    (fifo_count)
    );

    assign ifid_pkt = fifo_head;

endmodule
